exe_fwd_ctrl: RTL and testbench

EXE_FWD_CTRL -- requirements
Module: exe_fwd_ctrl

---
 rtl/exe_fwd_ctrl_pkg.sv | 33 +++
 rtl/exe_fwd_ctrl_if.sv | 38 +++
 rtl/exe_fwd_ctrl_hazard_detect.sv | 71 +++++++
 rtl/exe_fwd_ctrl.sv | 111 +++++++++++
 tb/tb_exe_fwd_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/exe_fwd_ctrl_pkg.sv
// Shared EXE-stage control definitions: forwarding select encodings, stall FSM
// states and default widths, used by the forwarding controller and the EXE operand mux.
package exe_fwd_ctrl_pkg;

    localparam int EXE_REG_ADDR_W = 5;
    localparam int EXE_CNT_W      = 16;

    typedef enum logic [1:0] {
        FWD_SEL_REG = 2'b00,
        FWD_SEL_MEM = 2'b01,
        FWD_SEL_WB  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_STALL1 = 2'b01,
        ST_STALL2 = 2'b10
    } stall_state_e;

    // EXE holds the younger producer, so its result wins over MEM's.
    function automatic fwd_sel_e fwd_pick(input logic match_e, input logic match_m);
        fwd_sel_e sel;
        if (match_e) begin
            sel = FWD_SEL_MEM;
        end else if (match_m) begin
            sel = FWD_SEL_WB;
        end else begin
            sel = FWD_SEL_REG;
        end
        return sel;
    endfunction

endpackage

// File: rtl/exe_fwd_ctrl_if.sv
// Bundle of pipeline-side inputs and forwarding/stall outputs of the controller.
interface exe_fwd_ctrl_if
    import exe_fwd_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = EXE_REG_ADDR_W,
    parameter int CNT_W      = EXE_CNT_W
);
    logic                  fwd_en;
    logic                  freeze;
    logic                  flush;
    logic [REG_ADDR_W-1:0] id_src1;
    logic [REG_ADDR_W-1:0] id_src2;
    logic                  id_src2_is_reg;
    logic                  id_is_store;
    logic [REG_ADDR_W-1:0] exe_dest;
    logic                  exe_wb_en;
    logic                  exe_mem_r_en;
    logic [REG_ADDR_W-1:0] mem_dest;
    logic                  mem_wb_en;
    logic                  hazard_stall;
    logic [1:0]            val1_sel;
    logic [1:0]            val2_sel;
    logic [1:0]            st_val_sel;
    logic [CNT_W-1:0]      stall_count;
    logic                  stall_err;

    modport master (
        output fwd_en, freeze, flush, id_src1, id_src2, id_src2_is_reg, id_is_store,
               exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
        input  hazard_stall, val1_sel, val2_sel, st_val_sel, stall_count, stall_err
    );

    modport slave (
        input  fwd_en, freeze, flush, id_src1, id_src2, id_src2_is_reg, id_is_store,
               exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
        output hazard_stall, val1_sel, val2_sel, st_val_sel, stall_count, stall_err
    );
endinterface

// File: rtl/exe_fwd_ctrl_hazard_detect.sv
// Combinational RAW hazard detection and next-cycle forwarding select generation.
module hazard_detect
    import exe_fwd_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = EXE_REG_ADDR_W
) (
    input  logic                  i_fwd_en,
    input  logic                  i_flush,
    input  logic [REG_ADDR_W-1:0] i_id_src1,
    input  logic [REG_ADDR_W-1:0] i_id_src2,
    input  logic                  i_id_src2_is_reg,
    input  logic                  i_id_is_store,
    input  logic [REG_ADDR_W-1:0] i_exe_dest,
    input  logic                  i_exe_wb_en,
    input  logic                  i_exe_mem_r_en,
    input  logic [REG_ADDR_W-1:0] i_mem_dest,
    input  logic                  i_mem_wb_en,
    output logic                  o_hazard_stall,
    output fwd_sel_e              o_val1_sel_nxt,
    output fwd_sel_e              o_val2_sel_nxt,
    output fwd_sel_e              o_st_val_sel_nxt
);
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};

    logic w_e1_s;
    logic w_e2_s;
    logic w_m1_s;
    logic w_m2_s;
    logic w_src2_needed_s;
    logic w_raw_stall_s;

    // Match flags, raw stall and the select values to load into EXE on the next edge.
    always_comb begin
        w_e1_s          = i_exe_wb_en & (i_exe_dest == i_id_src1) & (i_id_src1 != REG_ZERO);
        w_e2_s          = i_exe_wb_en & (i_exe_dest == i_id_src2) & (i_id_src2 != REG_ZERO);
        w_m1_s          = i_mem_wb_en & (i_mem_dest == i_id_src1) & (i_id_src1 != REG_ZERO);
        w_m2_s          = i_mem_wb_en & (i_mem_dest == i_id_src2) & (i_id_src2 != REG_ZERO);
        w_src2_needed_s = i_id_src2_is_reg | i_id_is_store;

        if (i_fwd_en) begin
            // With forwarding only a load in EXE is too late to bypass.
            w_raw_stall_s = i_exe_mem_r_en & (w_e1_s | (w_src2_needed_s & w_e2_s));
        end else begin
            w_raw_stall_s = w_e1_s | w_m1_s | (w_src2_needed_s & (w_e2_s | w_m2_s));
        end

        o_hazard_stall = w_raw_stall_s & ~i_flush;

        o_val1_sel_nxt   = FWD_SEL_REG;
        o_val2_sel_nxt   = FWD_SEL_REG;
        o_st_val_sel_nxt = FWD_SEL_REG;
        if (i_fwd_en & ~o_hazard_stall & ~i_flush) begin
            o_val1_sel_nxt = fwd_pick(w_e1_s, w_m1_s);
            if (i_id_src2_is_reg) begin
                o_val2_sel_nxt = fwd_pick(w_e2_s, w_m2_s);
            end else begin
                o_val2_sel_nxt = FWD_SEL_REG;
            end
            if (i_id_is_store) begin
                o_st_val_sel_nxt = fwd_pick(w_e2_s, w_m2_s);
            end else begin
                o_st_val_sel_nxt = FWD_SEL_REG;
            end
        end else begin
            o_val1_sel_nxt   = FWD_SEL_REG;
            o_val2_sel_nxt   = FWD_SEL_REG;
            o_st_val_sel_nxt = FWD_SEL_REG;
        end
    end

endmodule

// File: rtl/exe_fwd_ctrl.sv
// EXE forwarding controller: registered operand selects, stall-length FSM with
// sticky overrun flag, and saturating stall-cycle counter.
module exe_fwd_ctrl
    import exe_fwd_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = EXE_REG_ADDR_W,
    parameter int CNT_W      = EXE_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    exe_fwd_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic         w_hazard_s;
    fwd_sel_e     w_val1_nxt_s;
    fwd_sel_e     w_val2_nxt_s;
    fwd_sel_e     w_st_nxt_s;

    fwd_sel_e     r_val1_sel;
    fwd_sel_e     r_val2_sel;
    fwd_sel_e     r_st_val_sel;
    logic [CNT_W-1:0] r_stall_count;
    logic         r_stall_err;
    stall_state_e r_state;

    hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
        .i_fwd_en         (bus.fwd_en),
        .i_flush          (bus.flush),
        .i_id_src1        (bus.id_src1),
        .i_id_src2        (bus.id_src2),
        .i_id_src2_is_reg (bus.id_src2_is_reg),
        .i_id_is_store    (bus.id_is_store),
        .i_exe_dest       (bus.exe_dest),
        .i_exe_wb_en      (bus.exe_wb_en),
        .i_exe_mem_r_en   (bus.exe_mem_r_en),
        .i_mem_dest       (bus.mem_dest),
        .i_mem_wb_en      (bus.mem_wb_en),
        .o_hazard_stall   (w_hazard_s),
        .o_val1_sel_nxt   (w_val1_nxt_s),
        .o_val2_sel_nxt   (w_val2_nxt_s),
        .o_st_val_sel_nxt (w_st_nxt_s)
    );

    // Operand select registers follow the instruction into EXE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val1_sel   <= FWD_SEL_REG;
            r_val2_sel   <= FWD_SEL_REG;
            r_st_val_sel <= FWD_SEL_REG;
        end else if (!bus.freeze) begin
            r_val1_sel   <= w_val1_nxt_s;
            r_val2_sel   <= w_val2_nxt_s;
            r_st_val_sel <= w_st_nxt_s;
        end else begin
            r_val1_sel   <= r_val1_sel;
            r_val2_sel   <= r_val2_sel;
            r_st_val_sel <= r_st_val_sel;
        end
    end

    // Saturating count of non-frozen stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= {CNT_W{1'b0}};
        end else if (!bus.freeze && w_hazard_s && (r_stall_count != CNT_MAX)) begin
            r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_stall_count <= r_stall_count;
        end
    end

    // Stall-length FSM; a third consecutive stall cycle latches the error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_stall_err <= 1'b0;
        end else if (!bus.freeze) begin
            case (r_state)
                ST_RUN: begin
                    r_state <= w_hazard_s ? ST_STALL1 : ST_RUN;
                end
                ST_STALL1: begin
                    r_state <= w_hazard_s ? ST_STALL2 : ST_RUN;
                end
                ST_STALL2: begin
                    if (w_hazard_s) begin
                        r_state     <= ST_STALL2;
                        r_stall_err <= 1'b1;
                    end else begin
                        r_state     <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end else begin
            r_state     <= r_state;
            r_stall_err <= r_stall_err;
        end
    end

    assign bus.hazard_stall = w_hazard_s;
    assign bus.val1_sel     = r_val1_sel;
    assign bus.val2_sel     = r_val2_sel;
    assign bus.st_val_sel   = r_st_val_sel;
    assign bus.stall_count  = r_stall_count;
    assign bus.stall_err    = r_stall_err;

endmodule

// File: tb/tb_exe_fwd_ctrl.sv
// Randomized plus directed bench for exe_fwd_ctrl against a behavioural model.
module tb_exe_fwd_ctrl;
    localparam int AW = 5;
    localparam int CW = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    // model state
    int   m_v1, m_v2, m_st, m_cnt, m_run;
    bit   m_err;

    exe_fwd_ctrl_if #(.REG_ADDR_W(AW), .CNT_W(CW)) bus ();

    exe_fwd_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit mt(input bit wb, input int dest, input int r);
        return wb && (dest == r) && (r != 0);
    endfunction

    function automatic int pick(input bit e, input bit m);
        if (e) return 1;
        if (m) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_v1 = 0; m_v2 = 0; m_st = 0; m_cnt = 0; m_run = 0; m_err = 1'b0;
    endtask

    task automatic set_in(input bit fe, input bit fz, input bit fl,
                          input int s1, input int s2, input bit s2r, input bit st,
                          input int ed, input bit ewb, input bit eld,
                          input int md, input bit mwb);
        bus.fwd_en = fe; bus.freeze = fz; bus.flush = fl;
        bus.id_src1 = AW'(s1); bus.id_src2 = AW'(s2);
        bus.id_src2_is_reg = s2r; bus.id_is_store = st;
        bus.exe_dest = AW'(ed); bus.exe_wb_en = ewb; bus.exe_mem_r_en = eld;
        bus.mem_dest = AW'(md); bus.mem_wb_en = mwb;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".val1"}, int'(bus.val1_sel), m_v1);
        chk({tag, ".val2"}, int'(bus.val2_sel), m_v2);
        chk({tag, ".st"},   int'(bus.st_val_sel), m_st);
        chk({tag, ".cnt"},  int'(bus.stall_count), m_cnt);
        chk({tag, ".err"},  int'(bus.stall_err), int'(m_err));
    endtask

    // Called shortly after a rising edge with inputs already applied.
    task automatic step(input string tag);
        bit e1, e2, m1, m2, need, raw, hz;
        int n1, n2, n3;
        int s1, s2, ed, md;
        s1 = int'(bus.id_src1); s2 = int'(bus.id_src2);
        ed = int'(bus.exe_dest); md = int'(bus.mem_dest);
        e1 = mt(bus.exe_wb_en, ed, s1);
        e2 = mt(bus.exe_wb_en, ed, s2);
        m1 = mt(bus.mem_wb_en, md, s1);
        m2 = mt(bus.mem_wb_en, md, s2);
        need = bus.id_src2_is_reg || bus.id_is_store;
        if (bus.fwd_en) raw = bus.exe_mem_r_en && (e1 || (need && e2));
        else            raw = e1 || m1 || (need && (e2 || m2));
        hz = raw && !bus.flush;
        n1 = 0; n2 = 0; n3 = 0;
        if (bus.fwd_en && !hz && !bus.flush) begin
            n1 = pick(e1, m1);
            n2 = bus.id_src2_is_reg ? pick(e2, m2) : 0;
            n3 = bus.id_is_store ? pick(e2, m2) : 0;
        end
        #2;
        chk({tag, ".hazard"}, int'(bus.hazard_stall), int'(hz));
        @(posedge clk);
        if (!bus.freeze) begin
            m_v1 = n1; m_v2 = n2; m_st = n3;
            if (hz) begin
                if (m_cnt < (1 << CW) - 1) m_cnt++;
                m_run++;
                if (m_run >= 3) m_err = 1'b1;
            end else begin
                m_run = 0;
            end
        end
        #1;
        chk_regs(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        model_reset();
        chk_regs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        do_reset();

        // EXE ALU result forwarded to val1
        set_in(1, 0, 0, 5, 0, 0, 0, 5, 1, 0, 0, 0);
        step("alu_fwd");
        chk("alu_fwd.v1sel", int'(bus.val1_sel), 1);
        // load-use on src2 then WB forwarding
        set_in(1, 0, 0, 1, 7, 1, 0, 7, 1, 1, 0, 0);
        step("load_use");
        chk("load_use.cnt1", int'(bus.stall_count), 1);
        set_in(1, 0, 0, 1, 7, 1, 0, 7, 0, 0, 7, 1);
        step("load_wb");
        chk("load_wb.v2sel", int'(bus.val2_sel), 2);
        // EXE beats MEM; store value forwarded, val2 immediate
        set_in(1, 0, 0, 3, 3, 0, 1, 3, 1, 0, 3, 1);
        step("store_fwd");
        // register zero never matches; flush masks load-use
        set_in(1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 1);
        step("r0");
        set_in(1, 0, 1, 4, 0, 0, 0, 4, 1, 1, 0, 0);
        step("flush");
        // no forwarding: three stalls with a freeze in between
        set_in(0, 0, 0, 6, 0, 0, 0, 0, 0, 0, 6, 1);
        step("nofwd1");
        step("nofwd2");
        bus.freeze = 1'b1;
        step("frozen");
        bus.freeze = 1'b0;
        step("nofwd3");
        chk("nofwd3.errset", int'(bus.stall_err), 1);

        // build stall_count=9 and val1_sel=WB, then reset asynchronously mid-stall
        do_reset();
        set_in(0, 0, 0, 2, 0, 0, 0, 2, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) step("pre_rst");
        set_in(1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 2, 1);
        step("pre_rst_wb");
        set_in(0, 0, 0, 2, 0, 0, 0, 2, 1, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_regs("async_rst");
        chk("async_rst.hazard", int'(bus.hazard_stall), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // random traffic over a small register range for dense matches
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 9) == 0),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 1));
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
